// File: rtl/mfcc_pkg.sv
// Shared definitions for the MFCC back end: default widths, delta-stage state
// encoding and mod-3 slot arithmetic for the three-frame ring.
package mfcc_pkg;

  localparam int MFCC_DATA_WIDTH = 16;
  localparam int MFCC_NUM_CEPS   = 8;

  typedef enum logic [1:0] {
    DELTA_EMPTY  = 2'd0,
    DELTA_PRIMED = 2'd1,
    DELTA_FLUSH  = 2'd2
  } delta_state_t;

  function automatic logic [1:0] mod3_dec(input logic [1:0] slot);
    return (slot == 2'd0) ? 2'd2 : slot - 2'd1;
  endfunction

  function automatic logic [1:0] mod3_inc(input logic [1:0] slot);
    return (slot == 2'd2) ? 2'd0 : slot + 2'd1;
  endfunction

endpackage

// File: rtl/delta_frame_ring.sv
// Three-slot frame ring: one write port at (wp, k), combinational reads of
// frame t at (wp-1, k) and frame t-1 at (wp-2, k).
module delta_frame_ring
  import mfcc_pkg::*;
#(
  parameter int NUM_CEPS   = MFCC_NUM_CEPS,
  parameter int DATA_WIDTH = MFCC_DATA_WIDTH,
  localparam int KW        = (NUM_CEPS > 1) ? $clog2(NUM_CEPS) : 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [1:0]            wp,
  input  logic [KW-1:0]         k,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rd_t,
  output logic [DATA_WIDTH-1:0] rd_tm1
);

  logic [DATA_WIDTH-1:0] ring [3][NUM_CEPS];
  logic [1:0]            slot_t;
  logic [1:0]            slot_tm1;

  // Contents are don't-care after reset, so the ring carries no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      ring[wp][k] <= wdata;
    end
  end

  always_comb begin
    slot_t   = mod3_dec(wp);
    slot_tm1 = mod3_dec(slot_t);
    rd_t     = ring[slot_t][k];
    rd_tm1   = ring[slot_tm1][k];
  end

endmodule

// File: rtl/mfcc_delta.sv
// Temporal-derivative stage: pairs each static cepstral coefficient c[t][k]
// with its first-order delta (c[t+1][k] - c[t-1][k]) >>> 1.
module mfcc_delta
  import mfcc_pkg::*;
#(
  parameter int NUM_CEPS   = MFCC_NUM_CEPS,
  parameter int DATA_WIDTH = MFCC_DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] mfcc_in,
  input  logic                         valid_in,
  input  logic                         flush,
  output logic signed [DATA_WIDTH-1:0] static_out,
  output logic signed [DATA_WIDTH-1:0] delta_out,
  output logic                         valid_out,
  output logic                         last_out,
  output logic                         overrun
);

  localparam int KW = (NUM_CEPS > 1) ? $clog2(NUM_CEPS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NUM_CEPS - 1);

  delta_state_t state;
  logic [KW-1:0] k;
  logic [1:0]    wp;
  logic          have_prev;

  logic                         ring_we;
  logic [DATA_WIDTH-1:0]        rd_t;
  logic [DATA_WIDTH-1:0]        rd_tm1;
  logic signed [DATA_WIDTH-1:0] prev_val;
  logic signed [DATA_WIDTH-1:0] next_val;
  logic signed [DATA_WIDTH:0]   diff;
  logic signed [DATA_WIDTH-1:0] delta_calc;
  logic                         k_wrap;
  logic [KW-1:0]                k_next;

  delta_frame_ring #(
    .NUM_CEPS  (NUM_CEPS),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ring (
    .clk   (clk),
    .we    (ring_we),
    .wp    (wp),
    .k     (k),
    .wdata (mfcc_in),
    .rd_t  (rd_t),
    .rd_tm1(rd_tm1)
  );

  // Edge replication: missing neighbours fall back to frame t itself. The
  // difference is one bit wider so the floor shift always fits DATA_WIDTH.
  always_comb begin
    ring_we    = valid_in && (state != DELTA_FLUSH);
    prev_val   = have_prev ? rd_tm1 : rd_t;
    next_val   = (state == DELTA_FLUSH) ? rd_t : mfcc_in;
    diff       = {next_val[DATA_WIDTH-1], next_val} - {prev_val[DATA_WIDTH-1], prev_val};
    delta_calc = diff[DATA_WIDTH:1];
    k_wrap     = (k == K_LAST);
    k_next     = k_wrap ? '0 : k + KW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= DELTA_EMPTY;
      k          <= '0;
      wp         <= 2'd0;
      have_prev  <= 1'b0;
      overrun    <= 1'b0;
      valid_out  <= 1'b0;
      last_out   <= 1'b0;
      static_out <= '0;
      delta_out  <= '0;
    end else begin
      valid_out <= 1'b0;
      last_out  <= 1'b0;
      case (state)
        DELTA_EMPTY: begin
          have_prev <= 1'b0;
          if (valid_in) begin
            k <= k_next;
            if (k_wrap) begin
              wp    <= mod3_inc(wp);
              state <= DELTA_PRIMED;
            end
          end
        end

        // A beat always wins over a coincident flush request.
        DELTA_PRIMED: begin
          if (valid_in) begin
            valid_out  <= 1'b1;
            last_out   <= k_wrap;
            static_out <= rd_t;
            delta_out  <= delta_calc;
            k          <= k_next;
            if (k_wrap) begin
              wp        <= mod3_inc(wp);
              have_prev <= 1'b1;
            end
          end else if (flush && (k == '0)) begin
            state <= DELTA_FLUSH;
          end
        end

        DELTA_FLUSH: begin
          valid_out  <= 1'b1;
          last_out   <= k_wrap;
          static_out <= rd_t;
          delta_out  <= delta_calc;
          k          <= k_next;
          if (valid_in) begin
            overrun <= 1'b1;
          end
          if (k_wrap) begin
            state     <= DELTA_EMPTY;
            have_prev <= 1'b0;
          end
        end

        default: state <= DELTA_EMPTY;
      endcase
    end
  end

endmodule
